// File: rtl/down_cnt_pkg.sv
// Shared definitions for the down counter: FSM state encoding and default width.
// The autoreload variant of the counter is selected with DOWN_CNT_AUTORELOAD_EN.
package down_cnt_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/t_ff_sync.sv
// Single toggle flop with synchronous active-high reset and a parallel load.
// Priority is reset > load > toggle.
module t_ff_sync (
  input  logic clk,
  input  logic reset,
  input  logic T,
  input  logic D_load,
  input  logic load,
  output logic Q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = D_load;
    end else if (T) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/down_counter_nbit.sv
// Loadable N-bit down counter/timer built from toggle flops with a borrow chain.
// Define DOWN_CNT_AUTORELOAD_EN for periodic mode (reload instead of stopping at 0).
//
// Handshake: no valid/ready; load (highest after reset) and en are sampled at
// every rising edge, and all outputs are registered so they change only there.
module down_counter_nbit
  import down_cnt_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  output logic [N-1:0] Q,
  output logic         tc,
  output logic         busy
);

  cnt_state_e   state_q;
  cnt_state_e   state_d;
  logic         tc_q;
  logic         tc_d;
  logic [N-1:0] cnt;
  logic [N-1:0] t_en;
  logic [N-1:0] ld_val;
  logic         ld_all;
  logic         dec;
  logic         at_one;

  assign dec    = (state_q == RUN) & en & ~load;
  assign at_one = (cnt == N'(1));

`ifdef DOWN_CNT_AUTORELOAD_EN
  logic [N-1:0] reload_q;
  logic [N-1:0] reload_d;

  assign reload_d = load ? load_val : reload_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end

  // Terminal count reloads the period through the flops' load path.
  assign ld_all = load | (dec & at_one);
  assign ld_val = load ? load_val : reload_q;
`else
  assign ld_all = load;
  assign ld_val = load_val;
`endif

  // Borrow chain: bit i toggles when decrementing and all lower bits are 0.
  always_comb begin
    t_en[0] = dec;
    for (int i = 1; i < N; i++) begin
      t_en[i] = t_en[i-1] & ~cnt[i-1];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_bit
    t_ff_sync u_tff (
      .clk   (clk),
      .reset (reset),
      .T     (t_en[g]),
      .D_load(ld_val[g]),
      .load  (ld_all),
      .Q     (cnt[g])
    );
  end

  // State and terminal-count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tc_d    = 1'b0;
    if (load) begin
      state_d = (load_val != '0) ? RUN : IDLE;
    end else if (dec && at_one) begin
      tc_d = 1'b1;
`ifdef DOWN_CNT_AUTORELOAD_EN
      state_d = RUN;
`else
      state_d = IDLE;
`endif
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    tc   = tc_q;
    Q    = cnt;
  end

endmodule

// File: tb/tb_down_counter_nbit.sv
// Directed bench for down_counter_nbit (N=4); expectations follow
// DOWN_CNT_AUTORELOAD_EN when it is defined.
module tb_down_counter_nbit;

`ifdef DOWN_CNT_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic [3:0] Q;
  logic       tc;
  logic       busy;

  int tests_run;
  int tests_failed;
  int n_en;

  down_counter_nbit #(.N(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .Q       (Q),
    .tc      (tc),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int exp_q, input int exp_tc, input int exp_busy);
    check({tag, ".Q"}, 32'(Q), 32'(exp_q));
    check({tag, ".tc"}, 32'(tc), 32'(exp_tc));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    load = 1'b0;
    load_val = 4'd0;
    en = 1'b0;

    // 1: reset, then en without load does nothing
    step();
    step();
    check_out("reset", 0, 0, 0);
    reset = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("idle_en", 0, 0, 0);
    end

    // 2: load 5 and count down continuously
    en = 1'b0;
    load = 1'b1;
    load_val = 4'd5;
    step();
    load = 1'b0;
    check_out("load5", 5, 0, 1);
    en = 1'b1;
    for (int k = 4; k >= 1; k--) begin
      step();
      check_out("cnt5", k, 0, 1);
    end
    step();
    check_out("term5", AR ? 5 : 0, 1, AR ? 1 : 0);
    en = 1'b0;
    step();
    check_out("after5", AR ? 5 : 0, 0, AR ? 1 : 0);

    // 3: load 15, en alternating; 15 enabled edges reach terminal count
    load = 1'b1;
    load_val = 4'd15;
    step();
    load = 1'b0;
    check_out("load15", 15, 0, 1);
    n_en = 0;
    for (int i = 0; i < 30; i++) begin
      en = (i % 2 == 0);
      step();
      if (en) n_en++;
      check_out("alt15", (n_en < 15) ? 15 - n_en : (AR ? 15 : 0),
                (en && n_en == 15) ? 1 : 0, (AR || n_en < 15) ? 1 : 0);
    end

    // 4: load collides with terminal count; load wins
    en = 1'b0;
    load = 1'b1;
    load_val = 4'd3;
    step();
    load = 1'b0;
    en = 1'b1;
    step();
    check_out("run3_2", 2, 0, 1);
    step();
    check_out("run3_1", 1, 0, 1);
    load = 1'b1;
    load_val = 4'd9;
    step();
    load = 1'b0;
    check_out("reload9", 9, 0, 1);
    step();
    check_out("run9", 8, 0, 1);

    // 5: reset mid-run aborts without tc
    en = 1'b0;
    load = 1'b1;
    load_val = 4'd8;
    step();
    load = 1'b0;
    en = 1'b1;
    step();
    check_out("run8_7", 7, 0, 1);
    step();
    check_out("run8_6", 6, 0, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_out("abort", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("post_abort", 0, 0, 0);
    end

    // Boundaries: loading 0 stays idle; loading 1 terminates on the first enabled edge
    en = 1'b1;
    load = 1'b1;
    load_val = 4'd0;
    step();
    check_out("load0", 0, 0, 0);
    load_val = 4'd1;
    step();
    load = 1'b0;
    check_out("load1", 1, 0, 1);
    step();
    check_out("term1", AR ? 1 : 0, 1, AR ? 1 : 0);

`ifdef DOWN_CNT_AUTORELOAD_EN
    // 6: periodic mode, period 3
    en = 1'b0;
    load = 1'b1;
    load_val = 4'd3;
    step();
    load = 1'b0;
    en = 1'b1;
    check_out("ar_load3", 3, 0, 1);
    for (int i = 0; i < 9; i++) begin
      step();
      check_out("ar_run", (i % 3 == 0) ? 2 : ((i % 3 == 1) ? 1 : 3),
                (i % 3 == 2) ? 1 : 0, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/down_counter_nbit.md
Name: down_counter_nbit

Overview:
Synchronous N-bit loadable down counter/timer; the count-down counterpart of the team's up counters.
- Decrement is built from a chain of toggle flops with borrow logic: bit i toggles when decrementing and all lower bits are 0.
- Used as a programmable delay or timeout: load a value, count enabled cycles, flag terminal count.
- Sits beside the up counters in the counter library, as a standalone timer for higher-level FSMs.

Parameters:
- N, 4, counter width in bits (N >= 2).

Ports:
- clk  input  1  single clock, all state changes on its rising edge.
- reset  input  1  synchronous reset, active-high; sampled only at the rising edge of clk.
- load  input  1  when 1, capture load_val into the counter at the next edge.
- load_val  input  N  value to load (unsigned).
- en  input  1  count enable; one decrement per edge while RUN and en=1.
- Q  output  N  current count, registered.
- tc  output  1  terminal-count pulse, registered, high for exactly one cycle.
- busy  output  1  1 while FSM is in RUN.

Behaviour:
- Reset, when reset=1 at an edge: Q=0, tc=0, busy=0, FSM=IDLE, reload register=0.
  - reset overrides load and en.
  - Reset mid-run aborts the count with no tc.
- FSM states: IDLE (busy=0) and RUN (busy=1).
- Load priority order: reset > load > en.
- load=1 (any state):
  - Q <= load_val; reload register <= load_val; tc <= 0.
  - Next state is RUN if load_val != 0, otherwise IDLE.
  - Latency is 1 cycle: Q shows load_val the edge after load is sampled.
- RUN, en=1, load=0, Q>1: Q <= Q-1; tc <= 0.
- RUN, en=1, load=0, Q==1: Q <= 0; tc <= 1; next state IDLE.
  - busy falls in the same cycle that tc rises.
- RUN, en=0: Q holds; tc <= 0.
- IDLE, load=0: Q holds; en is ignored; tc <= 0. The counter never wraps below 0.
- load and (en with Q==1) at the same edge: load wins; no tc.
- Arithmetic:
  - Modulo 2^N is never reached because decrement stops at 0.
  - Toggle enable for bit i = (RUN & en & ~load) & (Q[i-1:0]==0).
  - Bit 0 toggles on every decrement.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: DOWN_CNT_AUTORELOAD_EN
- Defined:
  - In RUN with en=1, load=0, Q==1: Q <= reload register; tc <= 1; the FSM stays in RUN (periodic timer).
  - The period is the loaded value in enabled cycles; Q never shows 0 in steady state.
  - Loading 0 still goes to IDLE.
- Not defined: one-shot behaviour as described above. The reload register may be optimised away.

Decomposition:
- Package/header down_cnt_pkg: FSM state encodings (IDLE=1'b0, RUN=1'b1) and the default width constant.
- Sub-module t_ff_sync: single toggle flop.
  - Ports: clk, reset (sync, active-high), T, D_load, load, Q.
  - Load has priority over T.
  - Instantiated N times via generate; the borrow chain lives in down_counter_nbit.
- The FSM and tc register live in the top module.

Test Plan:
1. reset=1 for 2 edges, then en=1 with no load for 4 cycles -> Q=0, tc=0, busy=0 throughout.
2. N=4, load 5, then en=1 continuously:
   - Q sequence 5,4,3,2,1,0 on consecutive cycles.
   - tc=1 only in the cycle Q==0; busy 1 -> 0 in that same cycle.
3. load 15, en alternating 1/0:
   - Q decrements only after en=1 cycles.
   - tc asserts after exactly 15 enabled edges (30 cycles).
4. load 3; when Q==1 assert load=1, load_val=9, en=1 -> Q=9, tc stays 0, busy stays 1, then counts down from 9.
5. load 8, en=1; at Q==6 assert reset for one edge:
   - Q=0, busy=0, tc=0 after that edge.
   - Subsequent en pulses leave Q=0 until the next load.
6. With DOWN_CNT_AUTORELOAD_EN: load 3, en=1 continuously -> Q 3,2,1,3,2,1,...; tc=1 every 3rd cycle coincident with Q returning to 3; busy stays 1.
